mux_rr_arbiter: RTL

- Round-robin arbiter sharing one W-bit output channel between four requesters.
- Picks a winner among active requests and steers its data through a 4:1 select (the team's existing mux2s).
- Captures the selected word into a one-entry output register.
- Presents that word downstream on a valid/ready handshake.
- Sits between four producer ports and a single consumer; the sequencing layer for the shared 4:1 datapath.

---
 rtl/mux_rr_arbiter_pkg.sv | 13 +
 rtl/mux2s.sv | 24 ++
 rtl/mux_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state type for the round-robin output arbiter.
// Imported by the pick logic and the top.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/mux2s.sv
// Shared 4:1 word select driven by a 2-bit index.
// Used to steer the winning requester's data.
module mux2s #(
  parameter int w = 32
) (
  input  logic [w-1:0] d0,
  input  logic [w-1:0] d1,
  input  logic [w-1:0] d2,
  input  logic [w-1:0] d3,
  input  logic [1:0]   s,
  output logic [w-1:0] y
);

  // Pass through the word chosen by s.
  always_comb begin
    unique case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Rotating priority pick: first active request at or after ptr.
// Rotates req so ptr sits at bit 0, then fixed-priority encodes.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [6:0]       dbl;
  logic [3:0]       rot;
  logic [IDX_W-1:0] off;

  // Rotate, encode the offset, then add it back onto ptr.
  always_comb begin
    dbl     = {req[2:0], req};
    rot     = dbl[ptr +: 4];
    off     = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    winner  = ptr + off;
    any_req = |req;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter into a one-entry valid/ready register.
// MUX_RR_ARBITER_LOCK_EN adds a lock input that holds priority on the winner.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0] lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_sel,
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             load;
  logic             keep;
  logic [W-1:0]     mux_y;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  mux2s #(.w(W)) u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s  (winner),
    .y  (mux_y)
  );

  // Load decision, grant strobe and next register contents.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt     = '0;
`ifdef MUX_RR_ARBITER_LOCK_EN
    keep = lock[winner];
`else
    keep = 1'b0;
`endif
    load = any_req && (state_q == EMPTY || out_ready);
    if (load && rst_n) gnt[winner] = 1'b1;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (out_ready && !any_req) state_d = EMPTY;
    endcase
    if (load) begin
      state_d = FULL;
      data_d  = mux_y;
      sel_d   = winner;
      ptr_d   = keep ? winner : winner + 2'd1;
    end
  end

  // State, output word and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
